// File: rtl/missile_pool.sv
// missile_pool: N-slot player missile engine with a one-cycle overlay draw stage.
// Missiles spawn from the ship when fire is pressed, move up once per frame, and
// are retired when enemies report a hit or when they reach the top of the screen.
module missile_pool #(
  parameter int unsigned N_MISSILES = 4,
  parameter int unsigned MISSILE_W  = 4,
  parameter int unsigned MISSILE_H  = 12,
  parameter int unsigned SPEED      = 8,
  parameter int unsigned COOLDOWN   = 8,
  parameter int unsigned Y_TOP      = 0,
  parameter logic [11:0] COLOR      = 12'hFF0
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      fire,
  input  logic [10:0]               xpos_ship,
  input  logic [10:0]               ypos_ship,
  input  logic [N_MISSILES-1:0]     hit,
  input  logic [10:0]               hcount_in,
  input  logic [10:0]               vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [11:0]               rgb_in,
  output logic [10:0]               hcount_out,
  output logic [10:0]               vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [11:0]               rgb_out,
  output logic [N_MISSILES-1:0]     missile_active,
  output logic [N_MISSILES*11-1:0]  missile_x,
  output logic [N_MISSILES*11-1:0]  missile_y
);

  localparam logic [11:0] L_RETIRE = 12'(Y_TOP + SPEED);
  localparam logic [11:0] L_W      = 12'(MISSILE_W);
  localparam logic [11:0] L_H      = 12'(MISSILE_H);
  localparam logic [10:0] L_H11    = 11'(MISSILE_H);
  localparam logic [10:0] L_SPEED  = 11'(SPEED);
  localparam logic [7:0]  L_CD     = 8'(COOLDOWN);

  logic                  r_vblnk_q;
  logic                  r_fire_q;
  logic                  r_fire_pending;
  logic [7:0]            r_cd;
  logic [N_MISSILES-1:0] r_act;
  logic [10:0]           r_x [N_MISSILES];
  logic [10:0]           r_y [N_MISSILES];

  logic                  w_tick;
  logic                  w_fire_req;
  logic                  w_free;
  logic [2:0]            w_idx;
  logic                  w_spawn;
  logic                  w_cover;

  assign w_tick     = vblnk_in & ~r_vblnk_q;
  assign w_fire_req = r_fire_pending | (fire & ~r_fire_q);
  assign w_spawn    = w_tick & w_fire_req & (r_cd == '0) & w_free & (ypos_ship >= L_H11);

  // Lowest-index slot that is free before this cycle's updates.
  always_comb begin
    w_free = 1'b0;
    w_idx  = '0;
    for (int unsigned i = 0; i < N_MISSILES; i++) begin
      if (!r_act[i] && !w_free) begin
        w_free = 1'b1;
        w_idx  = 3'(i);
      end
    end
  end

  // Pixel coverage by any live missile; 12-bit compares so x+W never wraps.
  always_comb begin
    w_cover = 1'b0;
    for (int unsigned i = 0; i < N_MISSILES; i++) begin
      if (r_act[i]
          && ({1'b0, hcount_in} >= {1'b0, r_x[i]})
          && ({1'b0, hcount_in} <  ({1'b0, r_x[i]} + L_W))
          && ({1'b0, vcount_in} >= {1'b0, r_y[i]})
          && ({1'b0, vcount_in} <  ({1'b0, r_y[i]} + L_H)))
        w_cover = 1'b1;
    end
  end

  // Flatten slot state onto the packed status outputs.
  always_comb begin
    missile_x = '0;
    missile_y = '0;
    for (int unsigned i = 0; i < N_MISSILES; i++) begin
      missile_x[11*i +: 11] = r_x[i];
      missile_y[11*i +: 11] = r_y[i];
    end
  end

  assign missile_active = r_act;

  // Frame edge detect, fire latch and spawn cooldown.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_vblnk_q      <= 1'b0;
      r_fire_q       <= 1'b0;
      r_fire_pending <= 1'b0;
      r_cd           <= '0;
    end else begin
      r_vblnk_q <= vblnk_in;
      r_fire_q  <= fire;
      if (w_tick)
        r_fire_pending <= 1'b0;
      else if (fire && !r_fire_q)
        r_fire_pending <= 1'b1;
      if (w_tick) begin
        if (w_spawn)
          r_cd <= L_CD;
        else if (r_cd != '0)
          r_cd <= r_cd - 8'd1;
      end
    end
  end

  // Slot state: hits free immediately, ticks step or retire, spawn lands in a
  // slot that was already free so it never collides with that slot's own update.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_act <= '0;
      for (int unsigned i = 0; i < N_MISSILES; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_MISSILES; i++) begin
        if (hit[i])
          r_act[i] <= 1'b0;
        else if (w_tick && r_act[i]) begin
          if ({1'b0, r_y[i]} < L_RETIRE)
            r_act[i] <= 1'b0;
          else
            r_y[i] <= r_y[i] - L_SPEED;
        end
        if (w_spawn && (w_idx == 3'(i))) begin
          r_act[i] <= 1'b1;
          r_x[i]   <= xpos_ship;
          r_y[i]   <= ypos_ship - L_H11;
        end
      end
    end
  end

  // Video pipeline stage with missile overlay outside blanking.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= (w_cover && !(hblnk_in || vblnk_in)) ? COLOR : rgb_in;
    end
  end

endmodule
